// File: rtl/incr_stage.sv
// Handshaked +STEP stage with a two-entry skid buffer and a run-length watchdog.
// Define INCR_STAGE_SAT_EN to saturate the sum on overflow instead of wrapping.
module incr_stage #(
    parameter int unsigned        DATA_W    = 40,
    parameter logic [DATA_W-1:0]  STEP      = 'd1,
    parameter int unsigned        RUN_LIMIT = 50,
    parameter int unsigned        CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_carry,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              done
);

    localparam logic [CNT_W-1:0] RUN_LIMIT_C = CNT_W'(RUN_LIMIT);

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              skid_carry;
    logic [CNT_W-1:0]  run_cnt;

    logic              accept;
    logic              out_load;
    logic [DATA_W-1:0] sum_raw;
    logic              sum_carry;
    logic [DATA_W-1:0] res_data;
    logic              skid_valid_next;
    logic [CNT_W-1:0]  run_cnt_next;
    logic              done_next;
    logic [CNT_W-1:0]  beat_cnt_next;

    assign accept   = in_valid & in_ready;
    assign out_load = !out_valid | out_ready;

    always_comb begin
        {sum_carry, sum_raw} = {1'b0, in_data} + {1'b0, STEP};
`ifdef INCR_STAGE_SAT_EN
        res_data = sum_carry ? '1 : sum_raw;
`else
        res_data = sum_raw;
`endif
    end

    // Output register empties or refills first; skid only fills while output stalls.
    always_comb begin
        skid_valid_next = skid_valid;
        if (out_load)
            skid_valid_next = 1'b0;
        else if (accept)
            skid_valid_next = 1'b1;
    end

    always_comb begin
        run_cnt_next = run_cnt;
        done_next    = done;
        if (restart) begin
            run_cnt_next = '0;
            done_next    = 1'b0;
        end else if (!done) begin
            run_cnt_next = run_cnt + 1'b1;
            done_next    = (run_cnt_next > RUN_LIMIT_C);
        end
        beat_cnt_next = restart ? '0 : beat_cnt;
        if (accept && beat_cnt_next != '1)
            beat_cnt_next = beat_cnt_next + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_carry  <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_carry <= 1'b0;
            run_cnt    <= '0;
            done       <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            run_cnt    <= run_cnt_next;
            done       <= done_next;
            beat_cnt   <= beat_cnt_next;
            skid_valid <= skid_valid_next;
            // Ready is computed from next-state so it never depends on out_ready combinationally.
            in_ready   <= !skid_valid_next & !done_next;
            if (out_load) begin
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data;
                    out_carry <= skid_carry;
                end else if (accept) begin
                    out_valid <= 1'b1;
                    out_data  <= res_data;
                    out_carry <= sum_carry;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_data  <= res_data;
                skid_carry <= sum_carry;
            end
        end
    end

endmodule

// File: tb/tb_incr_stage.sv
// Directed bench for incr_stage: streaming vectors, back-pressure, watchdog,
// restart, asynchronous reset and beat counter saturation.
module tb_incr_stage;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        restart;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_data;
    logic        out_carry;
    logic [7:0]  beat_cnt;
    logic        done;

    logic        s_restart;
    logic        s_valid;
    logic        s_in_ready;
    logic [7:0]  s_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_data;
    logic        s_out_carry;
    logic [7:0]  s_beat_cnt;
    logic        s_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_l)
        if (!reset_l) cyc <= 0;
        else          cyc <= cyc + 1;

    incr_stage dut (
        .clk(clk), .reset_l(reset_l), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_carry(out_carry), .beat_cnt(beat_cnt), .done(done)
    );

    incr_stage #(.DATA_W(8), .STEP(8'd3), .RUN_LIMIT(255), .CNT_W(8)) dut_sat (
        .clk(clk), .reset_l(reset_l), .restart(s_restart),
        .in_valid(s_valid), .in_ready(s_in_ready), .in_data(s_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_carry(s_out_carry), .beat_cnt(s_beat_cnt), .done(s_done)
    );

    typedef struct {
        logic [39:0] din;
        logic [39:0] dout;
        logic        carry;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          c0;
    int          exp_beats;
    logic [7:0]  s_exp_data;

    initial begin
        vecs[0] = '{40'h00_0000_0005, 40'h00_0000_0006, 1'b0};
        vecs[1] = '{40'h00_0000_0000, 40'h00_0000_0001, 1'b0};
`ifdef INCR_STAGE_SAT_EN
        vecs[2] = '{40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1};
        s_exp_data = 8'hFF;
`else
        vecs[2] = '{40'hFF_FFFF_FFFF, 40'h00_0000_0000, 1'b1};
        s_exp_data = 8'h01;
`endif
        vecs[3] = '{40'hFF_FFFF_FFFE, 40'hFF_FFFF_FFFF, 1'b0};
        vecs[4] = '{40'h00_FFFF_FFFF, 40'h01_0000_0000, 1'b0};

        reset_l = 1'b0; restart = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        s_restart = 1'b0; s_valid = 1'b0; s_data = 8'hFE; s_out_ready = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_carry", out_carry, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_done", done, 0);
        #10 reset_l = 1'b1;
        #1 check("ready_low_before_edge", in_ready, 0);
        step();
        check("ready_rises_edge1", in_ready, 1);

        // Streaming vectors, one per cycle, result visible one cycle later
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].din;
            step();
            check("vec_valid", out_valid, 1);
            check("vec_data", out_data, vecs[i].dout);
            check("vec_carry", out_carry, vecs[i].carry);
            check("vec_ready", in_ready, 1);
            check("vec_beats", beat_cnt, i + 1);
        end
        in_valid = 1'b0;
        step();
        check("drain_a", out_valid, 0);

        // Back-pressure: 1,2,3 with out_ready low for 3 cycles after the first accept
        in_valid = 1'b1; in_data = 40'd1;
        step();
        check("bp_e1_data", out_data, 2);
        out_ready = 1'b0; in_data = 40'd2;
        step();
        check("bp_e2_data", out_data, 2);
        check("bp_e2_ready", in_ready, 0);
        check("bp_e2_beats", beat_cnt, 7);
        in_data = 40'd3;
        repeat (2) begin
            step();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, 2);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_beats", beat_cnt, 7);
        end
        out_ready = 1'b1;
        step();
        check("bp_e5_data", out_data, 3);
        check("bp_e5_ready", in_ready, 1);
        check("bp_e5_beats", beat_cnt, 7);
        step();
        check("bp_e6_data", out_data, 4);
        check("bp_e6_beats", beat_cnt, 8);
        in_valid = 1'b0;
        step();
        check("bp_e7_valid", out_valid, 0);

        // Watchdog: continuous input until done closes the stage
        c0 = cyc;
        exp_beats = 8 + (51 - c0);
        in_valid = 1'b1; in_data = 40'h123;
        while (cyc < 50) step();
        check("wd_pre_done", done, 0);
        check("wd_pre_ready", in_ready, 1);
        step();
        check("wd_done", done, 1);
        check("wd_ready_low", in_ready, 0);
        check("wd_beats", beat_cnt, exp_beats);
        check("wd_last_data", out_data, 40'h124);
        repeat (3) step();
        check("wd_beats_frozen", beat_cnt, exp_beats);
        check("wd_drained", out_valid, 0);
        check("wd_done_sticky", done, 1);
        check("wd_ready_still_low", in_ready, 0);

        // Restart reopens the input and clears counters
        restart = 1'b1; in_data = 40'h10;
        step();
        restart = 1'b0;
        check("rs_done", done, 0);
        check("rs_beats", beat_cnt, 0);
        check("rs_ready", in_ready, 1);
        check("rs_no_accept", out_valid, 0);
        step();
        check("rs_beats1", beat_cnt, 1);
        check("rs_data", out_data, 40'h11);
        step();
        check("rs_beats2", beat_cnt, 2);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("rs_accept_beats", beat_cnt, 1);

        // Reset with two beats stored
        out_ready = 1'b0; in_data = 40'h20;
        step();
        check("rst2_full", in_ready, 0);
        check("rst2_valid_before", out_valid, 1);
        #3 reset_l = 1'b0;
        #1;
        check("rst2_out_valid", out_valid, 0);
        check("rst2_out_data", out_data, 0);
        check("rst2_beats", beat_cnt, 0);
        check("rst2_done", done, 0);
        check("rst2_ready", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("rst2_no_stale", out_valid, 0);
        check("rst2_reopen", in_ready, 1);

        // Beat counter saturation (8-bit counter, 8-bit datapath, STEP=3)
        s_valid = 1'b1; s_out_ready = 1'b1;
        repeat (254) step();
        check("sat_beats_254", s_beat_cnt, 254);
        check("sat_data", s_out_data, s_exp_data);
        check("sat_carry", s_out_carry, 1);
        repeat (46) step();
        check("sat_beats_max", s_beat_cnt, 255);
        s_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/incr_stage.md
# incr_stage

Parametrised, handshaked increment stage: the next generation of the demo top-level incrementer. Each accepted word leaves one cycle later as `in_data + STEP`, with a carry flag. Valid/ready flow control with a two-entry skid buffer sustains one beat per cycle under back-pressure. A run-length watchdog replaces the hard simulation stop with a sticky `done` flag that closes the input, so the block can sit in synthesisable demo designs and in Verilator benches alike.

## Interface
Parameters:
- `DATA_W`, 40, datapath width in bits (≥ 2).
- `STEP`, 1, unsigned increment added to every beat (must be < 2^DATA_W).
- `RUN_LIMIT`, 50, number of run cycles before `done` asserts.
- `CNT_W`, 8, width of `run_cnt` and `beat_cnt`; must hold `RUN_LIMIT+1`.

Ports:
- `clk`, in, 1, single clock, rising edge.
- `reset_l`, in, 1, asynchronous active-low reset.
- `restart`, in, 1, synchronous pulse: clears `run_cnt`, `beat_cnt` and `done`; data path untouched.
- `in_valid`, in, 1, input word valid.
- `in_ready`, out, 1, stage can accept a word.
- `in_data`, in, DATA_W, input word.
- `out_valid`, out, 1, output word valid.
- `out_ready`, in, 1, downstream accepts.
- `out_data`, out, DATA_W, `in_data + STEP` of the oldest unconsumed beat.
- `out_carry`, out, 1, carry-out of that addition (overflow indicator).
- `beat_cnt`, out, CNT_W, accepted input beats since reset/restart; saturates at all-ones.
- `done`, out, 1, sticky run-limit reached.

## Operation
- Accept: `in_valid & in_ready`. Deliver: `out_valid & out_ready`.
- Adder: `{carry, sum} = {1'b0,in_data} + STEP`, DATA_W+1 bits. Sum is truncated to DATA_W (wrap-around). Result and carry are stored together.
- Storage: output register plus skid register (2 entries total), in FIFO order. Occupancy is 0, 1 or 2.
- `in_ready = (occupancy < 2 at the register stage... simplified:` `in_ready = !skid_full & !done`. The value is registered. No combinational path from `out_ready` to `in_ready`.
- Simultaneous accept and deliver with occupancy 1: occupancy stays 1, and the new result replaces the output register.
- Skid behaviour: if a beat is accepted while the output is stalled (`out_valid & !out_ready`), it lands in the skid register. On the next delivery, skid moves to the output register.
- Run watchdog: `run_cnt` starts at 0 and increments every cycle while `!done`. `done = (run_cnt > RUN_LIMIT)`, and it is sticky until reset or `restart`.
- When `done` is high, `in_ready` is forced low. Stored beats still drain normally.
- `restart` together with an accept: counters are cleared, then this beat is counted, so `beat_cnt=1`.
- `beat_cnt` increments on each accept and holds at 2^CNT_W−1.

## Timing
- Reset (`reset_l` low, asynchronous) drives these values immediately:
  - `in_ready=0`, `out_valid=0`, `out_data=0`, `out_carry=0`.
  - `beat_cnt=0`, `run_cnt=0`, `done=0`.
- `in_ready` rises on the first clock edge after `reset_l` is released.
- Latency: a beat accepted at edge N is visible on `out_*` after edge N (one cycle), if the output register is empty or delivering.
- Throughput: 1 beat/cycle with `out_ready` held high.
- Back-pressure: after `out_ready` drops, at most one further beat is accepted. `in_ready` then falls on the following edge.
- `done` rises in cycle RUN_LIMIT+1 after reset release. `in_ready` is low from that same cycle.
- Outputs hold stable while `out_valid & !out_ready`.
- Reset mid-transfer discards both stored beats. No partial output is allowed.

## Configuration
- `INCR_STAGE_SAT_EN` defined:
  - The adder saturates: on carry, `out_data` is all-ones.
  - `out_carry` still reports the overflow.
- `INCR_STAGE_SAT_EN` undefined: wrap-around, as above. This is the default.

## Test plan
- Reset released, `in_data=40'h0000000005` streamed with `out_ready=1`: `out_data=40'h0000000006`, `out_carry=0`, one cycle after accept, 1 beat/cycle.
- `in_data` all-ones, DATA_W=40:
  - Without the macro: `out_data=0`, `out_carry=1`.
  - With `INCR_STAGE_SAT_EN`: `out_data` all-ones, `out_carry=1`.
- Stream 1,2,3 with `out_ready` low for 3 cycles after the first accept:
  - Exactly 2 beats are held and `in_ready` drops.
  - After release, outputs are 2,3,4 in order, with nothing lost or duplicated.
- RUN_LIMIT=50, continuous `in_valid`:
  - `done=1` and `in_ready=0` from cycle 51 after reset.
  - `beat_cnt` freezes; remaining beats drain.
  - A `restart` pulse clears `done` and `beat_cnt` and reopens the input.
- `reset_l` pulsed low mid-burst with 2 beats stored: `out_valid` drops asynchronously, and all counters read 0.
- 300 accepts with CNT_W=8 and RUN_LIMIT=255: `beat_cnt` saturates at 255.
